alu_seq_param: RTL and testbench

Parametrised, multi-cycle signed ALU. It is the next generation of the team's 8-bit add/sub/mul/div block.
- Performs ADD, SUB, MUL (radix-2 Booth) and DIV (restoring, signed) on WIDTH-bit two's-complement operands.
- Uses a start/busy/done handshake and produces 2*WIDTH-bit results with status flags.
- Sits between the operand register file and the result bus of the datapath controller.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_div_core.sv | 43 ++++
 rtl/alu_seq_param.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential signed ALU: operation codes and FSM states.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      ADDSUB,
      MUL,
      DIV_PREP,
      DIV_ITER,
      FINISH
   } alu_state_t;

endpackage

// File: rtl/alu_div_core.sv
// Unsigned restoring divider on operand magnitudes; one quotient bit per step.
module alu_div_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem,
   output logic [WIDTH-1:0] quo
);

   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH+1:0] r_sh;
   logic [WIDTH+1:0] trial;

   always_comb begin
      r_sh  = {rem_q, quo[WIDTH-1]};
      trial = r_sh - {2'b00, dvs_q};
   end

   // trial's top bit is the borrow: set means the divisor did not fit this step
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo   <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo   <= dividend;
         dvs_q <= divisor;
      end else if (step) begin
         rem_q <= trial[WIDTH+1] ? r_sh[WIDTH:0] : trial[WIDTH:0];
         quo   <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
      end
   end

   assign rem = rem_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq_param.sv
// Multi-cycle signed ALU (add/sub, Booth radix-2 multiply, restoring divide)
// with a start/busy/done handshake and 2*WIDTH-bit results.
module alu_seq_param
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               ovf,
   output logic               dbz
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   alu_state_t state, state_nx;

   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   as_q;
   logic [WIDTH-1:0] acc_a, acc_q;
   logic             q_m1;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] div_rem, div_quo;

   logic capture, as_load, mul_init, mul_step, mag_load, div_load, div_step, fin, cnt_run, cnt_last;

   logic [WIDTH:0]     a_ext, b_ext, as_sum, acc_ext, booth_sum;
   logic [WIDTH-1:0]   div_q, div_r;
   logic [2*WIDTH-1:0] fin_res;
   logic               fin_ovf, fin_dbz;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      as_load  = 1'b0;
      mul_init = 1'b0;
      mul_step = 1'b0;
      mag_load = 1'b0;
      div_load = 1'b0;
      div_step = 1'b0;
      fin      = 1'b0;
      cnt_run  = 1'b0;
      cnt_last = (cnt == CNT_W'(WIDTH));
      case (state)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               case (op)
                  OP_ADD, OP_SUB: state_nx = ADDSUB;
                  OP_MUL:         state_nx = MUL;
                  default:        state_nx = DIV_PREP;
               endcase
            end
         end
         ADDSUB: begin
            as_load  = 1'b1;
            state_nx = FINISH;
         end
         MUL: begin
            cnt_run = 1'b1;
            if (cnt == '0) mul_init = 1'b1;
            else           mul_step = 1'b1;
            if (cnt_last) state_nx = FINISH;
         end
         DIV_PREP: begin
            mag_load = 1'b1;
            state_nx = DIV_ITER;
         end
         DIV_ITER: begin
            cnt_run = 1'b1;
            if (cnt == '0) div_load = 1'b1;
            else           div_step = 1'b1;
            if (cnt_last) state_nx = FINISH;
         end
         FINISH: begin
            fin      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Booth accumulator keeps only WIDTH bits: after every arithmetic shift its
   // (WIDTH+1)-bit value is the sign extension of those bits.
   always_comb begin
      a_ext   = {a_q[WIDTH-1], a_q};
      b_ext   = {b_q[WIDTH-1], b_q};
      as_sum  = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
      acc_ext = {acc_a[WIDTH-1], acc_a};
      case ({acc_q[0], q_m1})
         2'b01:   booth_sum = acc_ext + a_ext;
         2'b10:   booth_sum = acc_ext - a_ext;
         default: booth_sum = acc_ext;
      endcase

      div_q = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -div_quo : div_quo;
      div_r = a_q[WIDTH-1] ? -div_rem : div_rem;

      fin_res = '0;
      fin_ovf = 1'b0;
      fin_dbz = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            fin_res = {{(WIDTH-1){as_q[WIDTH]}}, as_q};
            fin_ovf = as_q[WIDTH] ^ as_q[WIDTH-1];
         end
         OP_MUL: fin_res = {acc_a, acc_q};
         default: begin
            if (b_q == '0) begin
               fin_res = {a_q, {WIDTH{1'b1}}};
               fin_dbz = 1'b1;
            end else begin
               fin_res = {div_r, div_q};
               fin_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         cnt    <= '0;
         as_q   <= '0;
         acc_a  <= '0;
         acc_q  <= '0;
         q_m1   <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
         dbz    <= 1'b0;
      end else begin
         if (capture) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
         end
         if (as_load) as_q <= as_sum;
         if (mul_init) begin
            acc_a <= '0;
            acc_q <= b_q;
            q_m1  <= 1'b0;
         end else if (mul_step) begin
            acc_a <= booth_sum[WIDTH:1];
            acc_q <= {booth_sum[0], acc_q[WIDTH-1:1]};
            q_m1  <= acc_q[0];
         end
         if (mag_load) begin
            mag_a <= a_q[WIDTH-1] ? -a_q : a_q;
            mag_b <= b_q[WIDTH-1] ? -b_q : b_q;
         end
         cnt <= cnt_run ? cnt + CNT_W'(1) : '0;
         if (capture)  busy <= 1'b1;
         else if (fin) busy <= 1'b0;
         done <= fin;
         if (fin) begin
            result <= fin_res;
            ovf    <= fin_ovf;
            dbz    <= fin_dbz;
         end
      end
   end

   alu_div_core #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .step     (div_step),
      .dividend (mag_a),
      .divisor  (mag_b),
      .rem      (div_rem),
      .quo      (div_quo)
   );

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param: directed literal cases plus randomized traffic
// compared every cycle against an integer-arithmetic model.
module tb_alu_seq_param;
   import alu_pkg::*;

   localparam int W    = 8;
   localparam int MINV = -(2 ** (W - 1));
   localparam int MAXV = (2 ** (W - 1)) - 1;

   logic           clk = 1'b0;
   logic           rst, start;
   logic [1:0]     op;
   logic [W-1:0]   a, b;
   logic           busy, done, ovf, dbz;
   logic [2*W-1:0] result;

   typedef struct {
      int             due;
      logic [2*W-1:0] res;
      logic           ov;
      logic           dz;
   } exp_t;

   exp_t           pend[$];
   int             cyc = 0;
   int             n_checks = 0;
   int             n_pass = 0;
   int             done_count = 0;
   bit             mon_en = 1'b0;
   logic [2*W-1:0] held_res = '0;
   logic           held_ov = 1'b0;
   logic           held_dz = 1'b0;
   int             cap_cyc, done_cyc, prev_done, dc0;

   alu_seq_param #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .ovf    (ovf),
      .dbz    (dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                                  input int now);
      exp_t        e;
      int          sa, sb, ex, q, r;
      logic [31:0] t, tq, tr;
      sa   = $signed(ai);
      sb   = $signed(bi);
      e.ov = 1'b0;
      e.dz = 1'b0;
      case (o)
         OP_ADD, OP_SUB: begin
            ex    = (o == OP_ADD) ? sa + sb : sa - sb;
            t     = ex;
            e.res = t[2*W-1:0];
            e.ov  = (ex > MAXV) || (ex < MINV);
            e.due = now + 2;
         end
         OP_MUL: begin
            ex    = sa * sb;
            t     = ex;
            e.res = t[2*W-1:0];
            e.due = now + W + 2;
         end
         default: begin
            if (sb == 0) begin
               q = -1; r = sa; e.dz = 1'b1;
            end else if (sa == MINV && sb == -1) begin
               q = MINV; r = 0; e.ov = 1'b1;
            end else begin
               q = sa / sb; r = sa % sb;
            end
            tq    = q;
            tr    = r;
            e.res = {tr[W-1:0], tq[W-1:0]};
            e.due = now + W + 3;
         end
      endcase
      return e;
   endfunction

   // Model side: accept a request only when nothing is outstanding.
   always @(posedge clk) begin
      cyc++;
      if (rst === 1'b1) begin
         pend.delete();
         held_res = '0;
         held_ov  = 1'b0;
         held_dz  = 1'b0;
      end else if (start === 1'b1 && pend.size() == 0) begin
         pend.push_back(model(op, a, b, cyc));
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         bit ed, eb;
         ed = (pend.size() > 0) && (pend[0].due == cyc);
         eb = (pend.size() > 0) && (cyc < pend[0].due);
         chk("busy", busy, eb);
         chk("done", done, ed);
         if (ed) begin
            held_res = pend[0].res;
            held_ov  = pend[0].ov;
            held_dz  = pend[0].dz;
            pend.pop_front();
            done_count++;
         end
         chk("result", result, held_res);
         chk("ovf", ovf, held_ov);
         chk("dbz", dbz, held_dz);
      end
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      cap_cyc = cyc;
      start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
   endtask

   task automatic wait_done();
      done_cyc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
      end
      if (done_cyc < 0) chk("done_seen", done, 1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return {1'b1, {(W-1){1'b0}}};
         1:       return '1;
         2:       return '0;
         3:       return W'(1);
         4:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      chk("reset_result", result, 0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      issue(OP_ADD, W'(100), W'(100));
      wait_done();
      chk("add_lat", done_cyc - cap_cyc, 2);
      chk("add_res", result, 16'h00C8);
      chk("add_ovf", ovf, 1);
      chk("add_dbz", dbz, 0);

      issue(OP_SUB, W'(-50), W'(100));
      wait_done();
      chk("sub_res", result, 16'hFF6A);
      chk("sub_ovf", ovf, 1);
      prev_done = done_cyc;
      issue(OP_ADD, W'(3), W'(4));
      wait_done();
      chk("b2b_lat", done_cyc - prev_done, 3);
      chk("b2b_res", result, 16'h0007);
      chk("b2b_ovf", ovf, 0);

      issue(OP_MUL, W'(-128), W'(-128));
      wait_done();
      chk("mul_lat", done_cyc - cap_cyc, 10);
      chk("mul_res", result, 16'h4000);
      chk("mul_ovf", ovf, 0);
      issue(OP_MUL, W'(-3), W'(7));
      wait_done();
      chk("mul2_res", result, 16'hFFEB);

      issue(OP_DIV, W'(-7), W'(2));
      wait_done();
      chk("div_lat", done_cyc - cap_cyc, 11);
      chk("div_res", result, 16'hFFFD);
      chk("div_ovf", ovf, 0);
      issue(OP_DIV, W'(-128), W'(-1));
      wait_done();
      chk("divmin_res", result, 16'h0080);
      chk("divmin_ovf", ovf, 1);

      issue(OP_DIV, W'(37), W'(0));
      dc0 = done_count;
      repeat (3) @(negedge clk);
      start = 1'b1; op = OP_ADD; a = W'(1); b = W'(1);
      @(negedge clk);
      start = 1'b0;
      wait_done();
      chk("dbz_lat", done_cyc - cap_cyc, 11);
      chk("dbz_res", result, 16'h25FF);
      chk("dbz_flag", dbz, 1);
      chk("dbz_ovf", ovf, 0);
      repeat (4) @(negedge clk);
      chk("one_done", done_count - dc0, 1);

      issue(OP_MUL, W'(5), W'(6));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_res", result, 0);
      dc0 = done_count;
      repeat (15) @(negedge clk);
      chk("abort_nodone", done_count - dc0, 0);
      issue(OP_ADD, W'(1), W'(1));
      wait_done();
      chk("post_rst_res", result, 16'h0002);

      for (int i = 0; i < 300; i++) begin
         logic [1:0]   o;
         logic [W-1:0] ra, rb;
         int           lat;
         o  = 2'($urandom);
         ra = pick();
         rb = pick();
         if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(o, ra, rb);
         if ($urandom_range(0, 3) == 0) begin
            lat = (o == OP_MUL) ? W + 2 : (o == OP_DIV) ? W + 3 : 2;
            repeat ($urandom_range(0, lat - 2)) @(negedge clk);
            start = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            start = 1'b0;
         end
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
